// File: rtl/rice_core_pkg.sv
// Shared types for the rice core load/store path: access encoding, exceptions, LSU states.
package rice_core_pkg;

  typedef enum logic [1:0] {
    ACCESS_NONE  = 2'b00,
    ACCESS_LOAD  = 2'b01,
    ACCESS_STORE = 2'b10
  } rice_core_access_type;

  // Mode encoding matches the RISC-V funct3 field of loads/stores.
  typedef enum logic [2:0] {
    MODE_B  = 3'b000,
    MODE_H  = 3'b001,
    MODE_W  = 3'b010,
    MODE_D  = 3'b011,
    MODE_BU = 3'b100,
    MODE_HU = 3'b101,
    MODE_WU = 3'b110
  } rice_core_access_mode;

  typedef struct packed {
    rice_core_access_type access_type;
    rice_core_access_mode access_mode;
  } rice_core_memory_access;

  typedef enum logic [2:0] {
    EXCEPTION_NONE               = 3'd0,
    EXCEPTION_LOAD_MISALIGNED    = 3'd1,
    EXCEPTION_LOAD_ACCESS_FAULT  = 3'd2,
    EXCEPTION_STORE_MISALIGNED   = 3'd3,
    EXCEPTION_STORE_ACCESS_FAULT = 3'd4
  } rice_core_exception;

  typedef enum logic [1:0] {
    LSU_IDLE     = 2'd0,
    LSU_REQUEST  = 2'd1,
    LSU_RESPONSE = 2'd2
  } rice_core_lsu_state;

  // Access size in bytes; 0 flags an unencoded mode.
  function automatic logic [3:0] get_access_size(input logic [2:0] mode);
    case (mode)
      MODE_B, MODE_BU: return 4'd1;
      MODE_H, MODE_HU: return 4'd2;
      MODE_W, MODE_WU: return 4'd4;
      MODE_D:          return 4'd8;
      default:         return 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/rice_core_lsu_data_align.sv
// Combinational lane steering for the LSU: byte strobes, store data shift and load
// data shift plus sign/zero extension.
module rice_core_lsu_data_align
  import rice_core_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]                  i_mode,
  input  logic [$clog2(XLEN/8)-1:0]   i_offset,
  input  logic [XLEN-1:0]             i_store_data,
  input  logic [XLEN-1:0]             i_read_data,
  output logic [XLEN/8-1:0]           o_strobe,
  output logic [XLEN-1:0]             o_write_data,
  output logic [XLEN-1:0]             o_load_data
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  logic [3:0]         size;
  logic [STRB_W-1:0]  mask;
  logic [OFF_W+2:0]   bit_shift;
  logic [XLEN-1:0]    shifted;

  always_comb begin
    size = get_access_size(i_mode);
    mask = '0;
    for (int i = 0; i < STRB_W; i++) begin
      mask[i] = (i < int'(size));
    end
    bit_shift    = {i_offset, 3'b000};
    o_strobe     = mask << i_offset;
    o_write_data = i_store_data << bit_shift;
    shifted      = i_read_data >> bit_shift;
  end

  // Sized casts of signed slices sign-extend; unsigned slices zero-extend.
  always_comb begin
    case (i_mode)
      MODE_B:  o_load_data = XLEN'($signed(shifted[7:0]));
      MODE_H:  o_load_data = XLEN'($signed(shifted[15:0]));
      MODE_W:  o_load_data = XLEN'($signed(shifted[31:0]));
      MODE_BU: o_load_data = XLEN'(shifted[7:0]);
      MODE_HU: o_load_data = XLEN'(shifted[15:0]);
      MODE_WU: o_load_data = XLEN'(shifted[31:0]);
      default: o_load_data = shifted;
    endcase
  end

endmodule

// File: rtl/rice_core_lsu.sv
// Rice core load/store unit: one op at a time over a request/response data bus.
// state    | meaning
// IDLE     | ready for a new op; also the cycle carrying the result pulse
// REQUEST  | bus request held with stable payload until i_bus_ready
// RESPONSE | waiting for the bus response; flushed_q suppresses the result
module rice_core_lsu
  import rice_core_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int ADDRESS_WIDTH = 32
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [4:0]                i_access,
  input  logic [XLEN-1:0]           i_address,
  input  logic [XLEN-1:0]           i_store_data,
  input  logic [4:0]                i_rd,
  input  logic                      i_flush,
  output logic                      o_bus_request,
  input  logic                      i_bus_ready,
  output logic                      o_bus_write,
  output logic [ADDRESS_WIDTH-1:0]  o_bus_address,
  output logic [XLEN/8-1:0]         o_bus_strobe,
  output logic [XLEN-1:0]           o_bus_write_data,
  input  logic                      i_bus_response_valid,
  input  logic [XLEN-1:0]           i_bus_read_data,
  input  logic                      i_bus_error,
  output logic                      o_result_valid,
  output logic                      o_result_write,
  output logic [4:0]                o_result_rd,
  output logic [XLEN-1:0]           o_result_data,
  output logic [2:0]                o_exception
);

  localparam int STRB_W = XLEN / 8;
  localparam int OFF_W  = $clog2(STRB_W);

  rice_core_lsu_state      state_q, state_d;
  rice_core_memory_access  access_in, access_q, access_d;
  logic [ADDRESS_WIDTH-1:0] address_q, address_d;
  logic [XLEN-1:0]         store_data_q, store_data_d;
  logic [4:0]              rd_q, rd_d;
  logic                    flushed_q, flushed_d;
  logic                    result_valid_q, result_valid_d;
  logic                    result_write_q, result_write_d;
  logic [4:0]              result_rd_q, result_rd_d;
  logic [XLEN-1:0]         result_data_q, result_data_d;
  rice_core_exception      exception_q, exception_d;

  logic [3:0]              size_in;
  logic                    misaligned_in;
  logic                    store_in;
  logic                    store_q;
  logic [STRB_W-1:0]       strobe;
  logic [XLEN-1:0]         write_data;
  logic [XLEN-1:0]         load_data;

  assign access_in = i_access;
  assign store_in  = (access_in.access_type == ACCESS_STORE);
  assign store_q   = (access_q.access_type == ACCESS_STORE);

  // Size-1 on the low three bits gives the offset mask; an 8-byte access yields 3'b111.
  always_comb begin
    size_in       = get_access_size(access_in.access_mode);
    misaligned_in = (size_in == 4'd0)
                 || ((XLEN == 32) && ((size_in == 4'd8) || (access_in.access_mode == MODE_WU)))
                 || ((i_address[2:0] & (size_in[2:0] - 3'd1)) != 3'd0);
  end

  rice_core_lsu_data_align #(.XLEN(XLEN)) u_data_align (
    .i_mode       (access_q.access_mode),
    .i_offset     (address_q[OFF_W-1:0]),
    .i_store_data (store_data_q),
    .i_read_data  (i_bus_read_data),
    .o_strobe     (strobe),
    .o_write_data (write_data),
    .o_load_data  (load_data)
  );

  always_comb begin
    state_d        = state_q;
    access_d       = access_q;
    address_d      = address_q;
    store_data_d   = store_data_q;
    rd_d           = rd_q;
    flushed_d      = flushed_q;
    result_valid_d = 1'b0;
    result_write_d = 1'b0;
    result_rd_d    = '0;
    result_data_d  = '0;
    exception_d    = EXCEPTION_NONE;

    case (state_q)
      LSU_IDLE: begin
        if (i_valid && (access_in.access_type != ACCESS_NONE) && !i_flush) begin
          access_d     = access_in;
          address_d    = i_address[ADDRESS_WIDTH-1:0];
          store_data_d = i_store_data;
          rd_d         = i_rd;
          flushed_d    = 1'b0;
          if (misaligned_in) begin
            result_valid_d = 1'b1;
            result_rd_d    = i_rd;
            exception_d    = store_in ? EXCEPTION_STORE_MISALIGNED : EXCEPTION_LOAD_MISALIGNED;
          end else begin
            state_d = LSU_REQUEST;
          end
        end
      end

      // Once the bus has taken the request a response is owed, so a flush on the
      // accept cycle only marks the op instead of abandoning it.
      LSU_REQUEST: begin
        if (i_bus_ready) begin
          state_d   = LSU_RESPONSE;
          flushed_d = i_flush;
        end else if (i_flush) begin
          state_d = LSU_IDLE;
        end
      end

      LSU_RESPONSE: begin
        if (i_bus_response_valid) begin
          state_d = LSU_IDLE;
          if (!(flushed_q || i_flush)) begin
            result_valid_d = 1'b1;
            result_rd_d    = rd_q;
            if (i_bus_error) begin
              exception_d = store_q ? EXCEPTION_STORE_ACCESS_FAULT : EXCEPTION_LOAD_ACCESS_FAULT;
            end else if (!store_q) begin
              result_write_d = (rd_q != 5'd0);
              result_data_d  = load_data;
            end
          end
        end else if (i_flush) begin
          flushed_d = 1'b1;
        end
      end

      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= LSU_IDLE;
      access_q       <= '0;
      address_q      <= '0;
      store_data_q   <= '0;
      rd_q           <= '0;
      flushed_q      <= 1'b0;
      result_valid_q <= 1'b0;
      result_write_q <= 1'b0;
      result_rd_q    <= '0;
      result_data_q  <= '0;
      exception_q    <= EXCEPTION_NONE;
    end else begin
      state_q        <= state_d;
      access_q       <= access_d;
      address_q      <= address_d;
      store_data_q   <= store_data_d;
      rd_q           <= rd_d;
      flushed_q      <= flushed_d;
      result_valid_q <= result_valid_d;
      result_write_q <= result_write_d;
      result_rd_q    <= result_rd_d;
      result_data_q  <= result_data_d;
      exception_q    <= exception_d;
    end
  end

  assign o_ready          = (state_q == LSU_IDLE);
  assign o_bus_request    = (state_q == LSU_REQUEST);
  assign o_bus_write      = o_bus_request && store_q;
  assign o_bus_address    = o_bus_request ? {address_q[ADDRESS_WIDTH-1:OFF_W], {OFF_W{1'b0}}} : '0;
  assign o_bus_strobe     = o_bus_request ? strobe : '0;
  assign o_bus_write_data = o_bus_request ? write_data : '0;
  assign o_result_valid   = result_valid_q;
  assign o_result_write   = result_write_q;
  assign o_result_rd      = result_rd_q;
  assign o_result_data    = result_data_q;
  assign o_exception      = exception_q;

endmodule

// File: tb/tb_rice_core_lsu.sv
// Scoreboard bench for rice_core_lsu: XLEN=32 and XLEN=64 instances share stimulus,
// a select bit routes the active instance's outputs to the monitor.
module tb_rice_core_lsu;
  import rice_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, valid, flush, bus_ready, resp_valid, bus_error;
  logic [4:0]  access, rd;
  logic [63:0] addr, sdata, rdata;
  logic        sel64;

  logic        r32_ready, r32_req, r32_bw, r32_rv, r32_rw;
  logic [31:0] r32_addr, r32_wdata, r32_rdata;
  logic [3:0]  r32_strb;
  logic [4:0]  r32_rrd;
  logic [2:0]  r32_exc;
  logic        r64_ready, r64_req, r64_bw, r64_rv, r64_rw;
  logic [63:0] r64_addr, r64_wdata, r64_rdata;
  logic [7:0]  r64_strb;
  logic [4:0]  r64_rrd;
  logic [2:0]  r64_exc;

  logic        m_ready, m_req, m_bw, m_rv, m_rw;
  logic [63:0] m_addr, m_wdata, m_rdata;
  logic [7:0]  m_strb;
  logic [4:0]  m_rrd;
  logic [2:0]  m_exc;

  always #5 clk = ~clk;

  rice_core_lsu #(.XLEN(32), .ADDRESS_WIDTH(32)) u_dut32 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid && !sel64), .o_ready(r32_ready),
    .i_access(access), .i_address(addr[31:0]), .i_store_data(sdata[31:0]), .i_rd(rd),
    .i_flush(flush), .o_bus_request(r32_req), .i_bus_ready(bus_ready), .o_bus_write(r32_bw),
    .o_bus_address(r32_addr), .o_bus_strobe(r32_strb), .o_bus_write_data(r32_wdata),
    .i_bus_response_valid(resp_valid), .i_bus_read_data(rdata[31:0]), .i_bus_error(bus_error),
    .o_result_valid(r32_rv), .o_result_write(r32_rw), .o_result_rd(r32_rrd),
    .o_result_data(r32_rdata), .o_exception(r32_exc)
  );

  rice_core_lsu #(.XLEN(64), .ADDRESS_WIDTH(64)) u_dut64 (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid && sel64), .o_ready(r64_ready),
    .i_access(access), .i_address(addr), .i_store_data(sdata), .i_rd(rd),
    .i_flush(flush), .o_bus_request(r64_req), .i_bus_ready(bus_ready), .o_bus_write(r64_bw),
    .o_bus_address(r64_addr), .o_bus_strobe(r64_strb), .o_bus_write_data(r64_wdata),
    .i_bus_response_valid(resp_valid), .i_bus_read_data(rdata), .i_bus_error(bus_error),
    .o_result_valid(r64_rv), .o_result_write(r64_rw), .o_result_rd(r64_rrd),
    .o_result_data(r64_rdata), .o_exception(r64_exc)
  );

  always_comb begin
    if (sel64) begin
      {m_ready, m_req, m_bw, m_rv, m_rw} = {r64_ready, r64_req, r64_bw, r64_rv, r64_rw};
      m_addr = r64_addr; m_wdata = r64_wdata; m_rdata = r64_rdata;
      m_strb = r64_strb; m_rrd = r64_rrd; m_exc = r64_exc;
    end else begin
      {m_ready, m_req, m_bw, m_rv, m_rw} = {r32_ready, r32_req, r32_bw, r32_rv, r32_rw};
      m_addr = {32'd0, r32_addr}; m_wdata = {32'd0, r32_wdata}; m_rdata = {32'd0, r32_rdata};
      m_strb = {4'd0, r32_strb}; m_rrd = r32_rrd; m_exc = r32_exc;
    end
  end

  typedef struct {logic write; logic [4:0] rd; logic [63:0] data; logic [2:0] exc;} res_t;
  typedef struct {logic write; logic [63:0] addr; logic [7:0] strobe; logic [63:0] wdata;} bus_t;
  res_t res_q[$];
  bus_t bus_q[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic exp_res(input logic w, input logic [4:0] r, input logic [63:0] d, input logic [2:0] e);
    res_t x;
    x.write = w; x.rd = r; x.data = d; x.exc = e;
    res_q.push_back(x);
  endtask

  task automatic exp_bus(input logic w, input logic [63:0] a, input logic [7:0] s, input logic [63:0] d);
    bus_t x;
    x.write = w; x.addr = a; x.strobe = s; x.wdata = d;
    bus_q.push_back(x);
  endtask

  // Monitor: bus payload is checked every request cycle, popped on the accepting cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_req) begin
        if (bus_q.size() == 0) begin
          chk("unexpected_bus_request", 64'(m_req), 64'd0);
        end else begin
          chk("bus_write", 64'(m_bw), 64'(bus_q[0].write));
          chk("bus_address", m_addr, bus_q[0].addr);
          chk("bus_strobe", 64'(m_strb), 64'(bus_q[0].strobe));
          chk("bus_wdata", m_wdata, bus_q[0].wdata);
          if (bus_ready) void'(bus_q.pop_front());
        end
      end
      if (m_rv) begin
        if (res_q.size() == 0) begin
          chk("unexpected_result", 64'(m_rv), 64'd0);
        end else begin
          res_t e;
          e = res_q.pop_front();
          chk("result_write", 64'(m_rw), 64'(e.write));
          chk("result_rd", 64'(m_rrd), 64'(e.rd));
          chk("result_data", m_rdata, e.data);
          chk("result_exception", 64'(m_exc), 64'(e.exc));
          chk("result_ready", 64'(m_ready), 64'd1);
        end
      end
    end
  end

  task automatic issue(input logic s64, input logic [1:0] typ, input logic [2:0] mode,
                       input logic [63:0] a, input logic [63:0] d, input logic [4:0] r,
                       input logic fl);
    @(posedge clk); #1;
    sel64 = s64; valid = 1'b1; access = {typ, mode}; addr = a; sdata = d; rd = r; flush = fl;
    @(posedge clk); #1;
    valid = 1'b0; flush = 1'b0;
  endtask

  // Bus model: stall with junk responses (must be ignored in REQUEST), accept, respond.
  task automatic serve(input int stall, input logic [63:0] d, input logic err,
                       input logic fl, input logic want_res);
    int n = 0;
    @(negedge clk);
    while (!m_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!m_req) begin
      chk("bus_request_timeout", 64'(m_req), 64'd1);
      return;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      resp_valid = 1'b1; rdata = 64'hA5A5_A5A5_A5A5_A5A5;
    end
    @(posedge clk); #1;
    resp_valid = 1'b0; bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    if (fl) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
    end
    resp_valid = 1'b1; rdata = d; bus_error = err;
    @(posedge clk); #1;
    resp_valid = 1'b0; bus_error = 1'b0;
    @(negedge clk);
    chk("result_latency", 64'(m_rv), 64'(want_res));
    repeat (2) @(posedge clk);
  endtask

  task automatic misaligned(input logic s64, input logic [1:0] typ, input logic [2:0] mode,
                            input logic [63:0] a, input logic [4:0] r, input logic [2:0] e);
    exp_res(1'b0, r, 64'd0, e);
    issue(s64, typ, mode, a, 64'd0, r, 1'b0);
    @(negedge clk);
    chk("misaligned_latency", 64'(m_rv), 64'd1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog_timeout");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; valid = 1'b0; flush = 1'b0; bus_ready = 1'b0; resp_valid = 1'b0;
    bus_error = 1'b0; access = '0; rd = '0; addr = '0; sdata = '0; rdata = '0; sel64 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int s = 0; s < 2; s++) begin
      sel64 = (s == 1);
      #1;
      chk("reset_ready", 64'(m_ready), 64'd1);
      chk("reset_outputs_zero", 64'(|{m_req, m_bw, m_rv, m_rw, m_addr, m_wdata, m_rdata,
                                      m_strb, m_rrd, m_exc}), 64'd0);
    end
    sel64 = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // XLEN=32 aligned traffic
    exp_bus(1'b0, 64'h1000, 8'h08, 64'd0);
    exp_res(1'b1, 5'd5, 64'h0000_0000_FFFF_FF80, EXCEPTION_NONE);
    issue(1'b0, ACCESS_LOAD, MODE_B, 64'h1003, 64'd0, 5'd5, 1'b0);
    serve(0, 64'h8012_3456, 1'b0, 1'b0, 1'b1);

    exp_bus(1'b1, 64'h1000, 8'h0C, 64'hBEEF_0000);
    exp_res(1'b0, 5'd0, 64'd0, EXCEPTION_NONE);
    issue(1'b0, ACCESS_STORE, MODE_H, 64'h1002, 64'h0000_BEEF, 5'd0, 1'b0);
    serve(0, 64'h1234_5678, 1'b0, 1'b0, 1'b1);

    exp_bus(1'b0, 64'h2000, 8'h0F, 64'd0);
    exp_res(1'b0, 5'd0, 64'h0000_0000_DEAD_BEEF, EXCEPTION_NONE);
    issue(1'b0, ACCESS_LOAD, MODE_W, 64'h2000, 64'd0, 5'd0, 1'b0);
    serve(5, 64'hDEAD_BEEF, 1'b0, 1'b0, 1'b1);

    exp_bus(1'b1, 64'h3000, 8'h02, 64'h0000_AB00);
    exp_res(1'b0, 5'd0, 64'd0, EXCEPTION_STORE_ACCESS_FAULT);
    issue(1'b0, ACCESS_STORE, MODE_B, 64'h3001, 64'h0000_00AB, 5'd0, 1'b0);
    serve(1, 64'd0, 1'b1, 1'b0, 1'b1);

    exp_bus(1'b0, 64'h1000, 8'h0C, 64'd0);
    exp_res(1'b1, 5'd9, 64'h0000_0000_0000_8001, EXCEPTION_NONE);
    issue(1'b0, ACCESS_LOAD, MODE_HU, 64'h1002, 64'd0, 5'd9, 1'b0);
    serve(0, 64'h8001_1234, 1'b0, 1'b0, 1'b1);

    // XLEN=32 misaligned and illegal sizes
    misaligned(1'b0, ACCESS_LOAD, MODE_W, 64'h1001, 5'd6, EXCEPTION_LOAD_MISALIGNED);
    misaligned(1'b0, ACCESS_STORE, MODE_W, 64'h1002, 5'd1, EXCEPTION_STORE_MISALIGNED);
    misaligned(1'b0, ACCESS_LOAD, MODE_D, 64'h0, 5'd2, EXCEPTION_LOAD_MISALIGNED);
    misaligned(1'b0, ACCESS_LOAD, MODE_WU, 64'h0, 5'd8, EXCEPTION_LOAD_MISALIGNED);

    // XLEN=64
    exp_bus(1'b0, 64'h0, 8'hF0, 64'd0);
    exp_res(1'b1, 5'd7, 64'h0000_0000_F000_0000, EXCEPTION_NONE);
    issue(1'b1, ACCESS_LOAD, MODE_WU, 64'h4, 64'd0, 5'd7, 1'b0);
    serve(0, 64'hF000_0000_1234_5678, 1'b0, 1'b0, 1'b1);

    exp_bus(1'b0, 64'h8, 8'hFF, 64'd0);
    exp_res(1'b0, 5'd3, 64'd0, EXCEPTION_LOAD_ACCESS_FAULT);
    issue(1'b1, ACCESS_LOAD, MODE_D, 64'h8, 64'd0, 5'd3, 1'b0);
    serve(0, 64'h1111_2222_3333_4444, 1'b1, 1'b0, 1'b1);

    exp_bus(1'b0, 64'h0, 8'hC0, 64'd0);
    exp_res(1'b1, 5'd10, 64'hFFFF_FFFF_FFFF_8001, EXCEPTION_NONE);
    issue(1'b1, ACCESS_LOAD, MODE_H, 64'h6, 64'd0, 5'd10, 1'b0);
    serve(0, 64'h8001_0000_0000_0000, 1'b0, 1'b0, 1'b1);

    exp_bus(1'b0, 64'h8, 8'hF0, 64'd0);
    exp_res(1'b1, 5'd11, 64'hFFFF_FFFF_8000_0000, EXCEPTION_NONE);
    issue(1'b1, ACCESS_LOAD, MODE_W, 64'hC, 64'd0, 5'd11, 1'b0);
    serve(0, 64'h8000_0000_0000_0000, 1'b0, 1'b0, 1'b1);

    exp_bus(1'b1, 64'h10, 8'hFF, 64'h1122_3344_5566_7788);
    exp_res(1'b0, 5'd0, 64'd0, EXCEPTION_NONE);
    issue(1'b1, ACCESS_STORE, MODE_D, 64'h10, 64'h1122_3344_5566_7788, 5'd0, 1'b0);
    serve(2, 64'd0, 1'b0, 1'b0, 1'b1);

    exp_bus(1'b1, 64'h10, 8'hF0, 64'hCAFE_F00D_0000_0000);
    exp_res(1'b0, 5'd12, 64'd0, EXCEPTION_NONE);
    issue(1'b1, ACCESS_STORE, MODE_W, 64'h14, 64'h0000_0000_CAFE_F00D, 5'd12, 1'b0);
    serve(0, 64'd0, 1'b0, 1'b0, 1'b1);

    misaligned(1'b1, ACCESS_LOAD, MODE_D, 64'h4, 5'd4, EXCEPTION_LOAD_MISALIGNED);

    // Flush cases on XLEN=32
    exp_bus(1'b0, 64'h1000, 8'h08, 64'd0);
    issue(1'b0, ACCESS_LOAD, MODE_B, 64'h1003, 64'd0, 5'd5, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    bus_q.delete();
    chk("flush_request_ready", 64'(m_ready), 64'd1);
    chk("flush_request_dropped", 64'(m_req), 64'd0);
    repeat (3) @(posedge clk);

    exp_bus(1'b0, 64'h2000, 8'h0F, 64'd0);
    issue(1'b0, ACCESS_LOAD, MODE_W, 64'h2000, 64'd0, 5'd4, 1'b0);
    serve(0, 64'h1234_5678, 1'b0, 1'b1, 1'b0);

    issue(1'b0, ACCESS_LOAD, MODE_W, 64'h1001, 64'd0, 5'd6, 1'b1);
    @(negedge clk);
    chk("flush_accept_no_result", 64'(m_rv), 64'd0);
    chk("flush_accept_ready", 64'(m_ready), 64'd1);
    issue(1'b0, ACCESS_NONE, MODE_W, 64'h2000, 64'd0, 5'd6, 1'b0);
    @(negedge clk);
    chk("none_access_ready", 64'(m_ready), 64'd1);
    chk("none_access_no_result", 64'(m_rv), 64'd0);
    repeat (3) @(posedge clk);

    // Reset while waiting for a response
    exp_bus(1'b0, 64'h2000, 8'h0F, 64'd0);
    issue(1'b0, ACCESS_LOAD, MODE_W, 64'h2000, 64'd0, 5'd4, 1'b0);
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("reset_mid_ready", 64'(m_ready), 64'd1);
    chk("reset_mid_zero", 64'(|{m_req, m_rv, m_rw, m_exc, m_strb}), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; resp_valid = 1'b1; rdata = 64'h5555_5555;
    @(posedge clk); #1;
    resp_valid = 1'b0;
    @(negedge clk);
    chk("late_response_ignored", 64'(m_rv), 64'd0);
    repeat (3) @(posedge clk);

    chk("result_queue_drained", 64'(res_q.size()), 64'd0);
    chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
